// File: rtl/spi_target_if.sv
// Byte-level and pin-level signal bundle for the SPI target endpoint.
// The slave modport is the endpoint's view; master is the core/pin side.
interface spi_target_if;
   logic       spi_clk_i;
   logic       spi_mosi_i;
   logic       spi_cs_i;
   logic       spi_miso_o;
   logic       spi_miso_oe_o;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic [7:0] tx_data_i;
   logic       tx_valid_i;
   logic       tx_accept_o;
   logic       tx_underrun_o;
   logic       cs_active_o;
   logic       frame_end_o;

   modport slave (
      input  spi_clk_i, spi_mosi_i, spi_cs_i, tx_data_i, tx_valid_i,
      output spi_miso_o, spi_miso_oe_o, rx_data_o, rx_valid_o,
             tx_accept_o, tx_underrun_o, cs_active_o, frame_end_o
   );

   modport master (
      output spi_clk_i, spi_mosi_i, spi_cs_i, tx_data_i, tx_valid_i,
      input  spi_miso_o, spi_miso_oe_o, rx_data_o, rx_valid_o,
             tx_accept_o, tx_underrun_o, cs_active_o, frame_end_o
   );
endinterface

// File: rtl/spi_target.sv
// SPI target endpoint. SCK/MOSI/CS are oversampled in clk_i through 2-FF
// synchronisers; received bytes leave on a valid pulse, transmit bytes come
// in through a single holding register with a valid/accept handshake.
module spi_target #(
   parameter bit         CPOL    = 1'b0,
   parameter bit         CPHA    = 1'b0,
   parameter logic [7:0] TX_IDLE = 8'hFF
) (
   input logic         clk_i,
   input logic         rst_i,
   spi_target_if.slave bus
);
   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   // Data is sampled on the rising SCK edge for modes 0 and 3, falling otherwise.
   localparam bit SAMPLE_ON_FALL = CPOL ^ CPHA;

   logic       sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_prev_q, sck_prev_d;
   logic       mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
   logic       cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d, cs_prev_q, cs_prev_d;
   state_e     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       first_q, first_d;
   logic [6:0] rx_shift_q, rx_shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic       hold_valid_q, hold_valid_d;
   logic [7:0] hold_data_q, hold_data_d;
   logic       underrun_q, underrun_d;
   logic       frame_end_q, frame_end_d;
   logic       miso_oe_q, miso_oe_d;

   logic       sck_rise, sck_fall, cs_fall, cs_rise;
   logic       sample_edge, shift_edge, hold_write, load;

   assign sck_rise    = sck_s2_q & ~sck_prev_q;
   assign sck_fall    = ~sck_s2_q & sck_prev_q;
   assign cs_fall     = ~cs_s2_q & cs_prev_q;
   assign cs_rise     = cs_s2_q & ~cs_prev_q;
   assign sample_edge = SAMPLE_ON_FALL ? sck_fall : sck_rise;
   assign shift_edge  = SAMPLE_ON_FALL ? sck_rise : sck_fall;
   // A write can only land while the holding register is empty.
   assign hold_write  = bus.tx_valid_i & ~hold_valid_q;

   // Next-state logic: synchronisers, frame FSM, shifters and holding register.
   always_comb begin
      sck_s1_d     = bus.spi_clk_i;
      sck_s2_d     = sck_s1_q;
      sck_prev_d   = sck_s2_q;
      mosi_s1_d    = bus.spi_mosi_i;
      mosi_s2_d    = mosi_s1_q;
      cs_s1_d      = bus.spi_cs_i;
      cs_s2_d      = cs_s1_q;
      cs_prev_d    = cs_s2_q;
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      first_d      = first_q;
      rx_shift_d   = rx_shift_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      tx_shift_d   = tx_shift_q;
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      underrun_d   = 1'b0;
      frame_end_d  = 1'b0;
      miso_oe_d    = miso_oe_q;
      load         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d   = ST_ACTIVE;
               miso_oe_d = 1'b1;
               bit_cnt_d = 3'd0;
               // With CPHA=0 the first bit must be on MISO before the first
               // SCK edge, so the byte is loaded on CS fall itself.
               first_d   = ~CPHA;
               load      = ~CPHA;
            end
         end
         ST_ACTIVE: begin
            if (cs_rise) begin
               // Abort any partial byte; the holding register is untouched.
               state_d     = ST_IDLE;
               miso_oe_d   = 1'b0;
               bit_cnt_d   = 3'd0;
               first_d     = 1'b0;
               rx_shift_d  = 7'd0;
               frame_end_d = 1'b1;
            end else begin
               if (sample_edge) begin
                  rx_shift_d = {rx_shift_q[5:0], mosi_s2_q};
                  bit_cnt_d  = bit_cnt_q + 3'd1;
                  first_d    = 1'b0;
                  if (bit_cnt_q == 3'd7) begin
                     rx_data_d  = {rx_shift_q, mosi_s2_q};
                     rx_valid_d = 1'b1;
                  end
               end
               // A shift edge before anything was sampled would reload the
               // byte just loaded on CS fall, so it is ignored.
               if (shift_edge && !first_q) begin
                  if (bit_cnt_q == 3'd0) begin
                     load = 1'b1;
                  end else begin
                     tx_shift_d = {tx_shift_q[6:0], 1'b0};
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         if (hold_valid_q) begin
            tx_shift_d   = hold_data_q;
            hold_valid_d = 1'b0;
         end else begin
            tx_shift_d = TX_IDLE;
            underrun_d = 1'b1;
         end
      end
      // Only reachable when the register was empty, so a coincident load
      // has already taken TX_IDLE and this byte waits for the next load.
      if (hold_write) begin
         hold_valid_d = 1'b1;
         hold_data_d  = bus.tx_data_i;
      end
   end

   // State register with synchronous active-low reset to idle pin levels.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         sck_s1_q     <= CPOL;
         sck_s2_q     <= CPOL;
         sck_prev_q   <= CPOL;
         mosi_s1_q    <= 1'b0;
         mosi_s2_q    <= 1'b0;
         cs_s1_q      <= 1'b1;
         cs_s2_q      <= 1'b1;
         cs_prev_q    <= 1'b1;
         state_q      <= ST_IDLE;
         bit_cnt_q    <= 3'd0;
         first_q      <= 1'b0;
         rx_shift_q   <= 7'd0;
         rx_data_q    <= 8'd0;
         rx_valid_q   <= 1'b0;
         tx_shift_q   <= 8'd0;
         hold_valid_q <= 1'b0;
         hold_data_q  <= 8'd0;
         underrun_q   <= 1'b0;
         frame_end_q  <= 1'b0;
         miso_oe_q    <= 1'b0;
      end else begin
         sck_s1_q     <= sck_s1_d;
         sck_s2_q     <= sck_s2_d;
         sck_prev_q   <= sck_prev_d;
         mosi_s1_q    <= mosi_s1_d;
         mosi_s2_q    <= mosi_s2_d;
         cs_s1_q      <= cs_s1_d;
         cs_s2_q      <= cs_s2_d;
         cs_prev_q    <= cs_prev_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         first_q      <= first_d;
         rx_shift_q   <= rx_shift_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         tx_shift_q   <= tx_shift_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         underrun_q   <= underrun_d;
         frame_end_q  <= frame_end_d;
         miso_oe_q    <= miso_oe_d;
      end
   end

   assign bus.spi_miso_o    = tx_shift_q[7];
   assign bus.spi_miso_oe_o = miso_oe_q;
   assign bus.rx_data_o     = rx_data_q;
   assign bus.rx_valid_o    = rx_valid_q;
   assign bus.tx_accept_o   = ~hold_valid_q;
   assign bus.tx_underrun_o = underrun_q;
   assign bus.cs_active_o   = (state_q == ST_ACTIVE);
   assign bus.frame_end_o   = frame_end_q;
endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a mode-0 instance and a CPOL=1/CPHA=1 instance,
// driven by a bit-banged SPI master and checked against a byte-level model
// of the holding register (one load per byte slot, TX_IDLE when empty).
module tb_spi_target;
   localparam int HALF = 8;
   localparam logic [14:0] RST_VALS = {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spi_target_if if0 ();
   spi_target_if if1 ();

   spi_target #(.CPOL(1'b0), .CPHA(1'b0), .TX_IDLE(8'hFF)) dut0 (
      .clk_i(clk), .rst_i(rst_n), .bus(if0)
   );
   spi_target #(.CPOL(1'b1), .CPHA(1'b1), .TX_IDLE(8'hFF)) dut1 (
      .clk_i(clk), .rst_i(rst_n), .bus(if1)
   );

   int vectors = 0;
   int miscompares = 0;

   // Pulse monitors, sampled on the falling clock edge.
   int         rxv_cnt[2]  = '{0, 0};
   int         urun_cnt[2] = '{0, 0};
   int         fend_cnt[2] = '{0, 0};
   logic [7:0] rxq0[$];
   logic [7:0] rxq1[$];

   always @(negedge clk) begin
      if (if0.rx_valid_o === 1'b1) begin rxq0.push_back(if0.rx_data_o); rxv_cnt[0]++; end
      if (if1.rx_valid_o === 1'b1) begin rxq1.push_back(if1.rx_data_o); rxv_cnt[1]++; end
      if (if0.tx_underrun_o === 1'b1) urun_cnt[0]++;
      if (if1.tx_underrun_o === 1'b1) urun_cnt[1]++;
      if (if0.frame_end_o === 1'b1) fend_cnt[0]++;
      if (if1.frame_end_o === 1'b1) fend_cnt[1]++;
   end

   // Reference model: holding register per instance plus expected underruns.
   bit         hold_v[2];
   logic [7:0] hold_d[2];
   int         exp_urun[2] = '{0, 0};

   logic [7:0] mosi_b[8];
   int         plan[9];

   function automatic logic [7:0] model_load(input int inst);
      logic [7:0] v;
      if (hold_v[inst]) begin
         v = hold_d[inst];
         hold_v[inst] = 1'b0;
      end else begin
         v = 8'hFF;
         exp_urun[inst]++;
      end
      return v;
   endfunction

   function automatic logic get_oe(input int inst);
      return (inst == 0) ? if0.spi_miso_oe_o : if1.spi_miso_oe_o;
   endfunction
   function automatic logic get_act(input int inst);
      return (inst == 0) ? if0.cs_active_o : if1.cs_active_o;
   endfunction
   function automatic logic get_acc(input int inst);
      return (inst == 0) ? if0.tx_accept_o : if1.tx_accept_o;
   endfunction
   function automatic logic [7:0] get_rxq(input int inst, input int idx);
      return (inst == 0) ? rxq0[idx] : rxq1[idx];
   endfunction

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_cs(input int inst, input logic v);
      if (inst == 0) if0.spi_cs_i = v; else if1.spi_cs_i = v;
   endtask

   // Write one byte into the holding register if the model says it is empty.
   task automatic maybe_write(input int inst, input int v);
      logic [7:0] d;
      if (v < 0 || hold_v[inst]) return;
      d = v[7:0];
      vectors++;
      if (get_acc(inst) !== 1'b1) begin
         miscompares++;
         $display("FAIL accept_before_write inst%0d: got %b want 1", inst, get_acc(inst));
      end
      if (inst == 0) begin if0.tx_data_i = d; if0.tx_valid_i = 1'b1; end
      else begin if1.tx_data_i = d; if1.tx_valid_i = 1'b1; end
      wait_clks(1);
      if0.tx_valid_i = 1'b0;
      if1.tx_valid_i = 1'b0;
      hold_v[inst] = 1'b1;
      hold_d[inst] = d;
      vectors++;
      if (get_acc(inst) !== 1'b0) begin
         miscompares++;
         $display("FAIL accept_after_write inst%0d: got %b want 0", inst, get_acc(inst));
      end
   endtask

   // Bit-bang nbits MSB first; returns what was read on MISO. For mode 0 a
   // 'last' byte leaves SCK high so CS can rise before the trailing edge.
   task automatic spi_bits(input int inst, input logic [7:0] b, input int nbits,
                           input bit last, output logic [7:0] rd);
      rd = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         if (inst == 0) begin
            if0.spi_mosi_i = b[7-i];
            wait_clks(HALF);
            rd = {rd[6:0], if0.spi_miso_o};
            if0.spi_clk_i = 1'b1;
            wait_clks(HALF);
            if (!(last && i == nbits - 1)) if0.spi_clk_i = 1'b0;
         end else begin
            if1.spi_clk_i  = 1'b0;
            if1.spi_mosi_i = b[7-i];
            wait_clks(HALF);
            rd = {rd[6:0], if1.spi_miso_o};
            if1.spi_clk_i = 1'b1;
            wait_clks(HALF);
         end
      end
      if (inst == 0 && !last) wait_clks(HALF);
   endtask

   task automatic cs_rise(input int inst);
      set_cs(inst, 1'b1);
      wait_clks(HALF);
      if (inst == 0) if0.spi_clk_i = 1'b0;
      wait_clks(HALF);
   endtask

   // One CS-framed transfer of n bytes from mosi_b, TX writes from plan.
   task automatic run_frame(input int inst, input int n, input string name);
      logic [7:0] exp_rd[9];
      logic [7:0] rd, got;
      int r0, u0, f0, eu0, nrx;
      r0 = rxv_cnt[inst]; u0 = urun_cnt[inst]; f0 = fend_cnt[inst]; eu0 = exp_urun[inst];
      if (inst == 0) maybe_write(0, plan[0]);
      set_cs(inst, 1'b0);
      wait_clks(HALF);
      if (inst == 0) exp_rd[0] = model_load(0);
      vectors++;
      if ({get_act(inst), get_oe(inst), get_acc(inst)} !== {2'b11, ~hold_v[inst]}) begin
         miscompares++;
         $display("FAIL %s cs_fall act/oe/accept inst%0d: got %b want %b", name, inst,
                  {get_act(inst), get_oe(inst), get_acc(inst)}, {2'b11, ~hold_v[inst]});
      end
      for (int k = 0; k < n; k++) begin
         if (inst == 0) begin
            if (k < n - 1) maybe_write(0, plan[k+1]);
            spi_bits(0, mosi_b[k], 8, (k == n - 1), rd);
            if (k < n - 1) exp_rd[k+1] = model_load(0);
         end else begin
            maybe_write(1, plan[k]);
            exp_rd[k] = model_load(1);
            spi_bits(1, mosi_b[k], 8, 1'b0, rd);
         end
         vectors++;
         if (rd !== exp_rd[k]) begin
            miscompares++;
            $display("FAIL %s miso inst%0d byte%0d: got %h want %h", name, inst, k, rd, exp_rd[k]);
         end
      end
      cs_rise(inst);
      nrx = rxv_cnt[inst] - r0;
      vectors++;
      if (nrx != n) begin
         miscompares++;
         $display("FAIL %s rx_valid_count inst%0d: got %0d want %0d", name, inst, nrx, n);
      end
      for (int k = 0; k < n && k < nrx; k++) begin
         got = get_rxq(inst, r0 + k);
         vectors++;
         if (got !== mosi_b[k]) begin
            miscompares++;
            $display("FAIL %s rx_data inst%0d byte%0d: got %h want %h", name, inst, k, got, mosi_b[k]);
         end
      end
      vectors++;
      if (urun_cnt[inst] - u0 != exp_urun[inst] - eu0) begin
         miscompares++;
         $display("FAIL %s underrun_count inst%0d: got %0d want %0d", name, inst,
                  urun_cnt[inst] - u0, exp_urun[inst] - eu0);
      end
      vectors++;
      if (fend_cnt[inst] - f0 != 1 || {get_act(inst), get_oe(inst)} !== 2'b00) begin
         miscompares++;
         $display("FAIL %s frame_end/act/oe inst%0d: got %0d,%b want 1,00", name, inst,
                  fend_cnt[inst] - f0, {get_act(inst), get_oe(inst)});
      end
   endtask

   task automatic test_reset();
      logic [14:0] got;
      rst_n = 1'b0;
      if0.spi_clk_i = 1'b0; if0.spi_cs_i = 1'b1; if0.spi_mosi_i = 1'b0;
      if0.tx_valid_i = 1'b0; if0.tx_data_i = 8'h00;
      if1.spi_clk_i = 1'b1; if1.spi_cs_i = 1'b1; if1.spi_mosi_i = 1'b0;
      if1.tx_valid_i = 1'b0; if1.tx_data_i = 8'h00;
      hold_v = '{1'b0, 1'b0};
      wait_clks(4);
      got = {if0.spi_miso_o, if0.spi_miso_oe_o, if0.rx_data_o, if0.rx_valid_o,
             if0.tx_accept_o, if0.tx_underrun_o, if0.cs_active_o, if0.frame_end_o};
      vectors++;
      if (got !== RST_VALS) begin
         miscompares++;
         $display("FAIL reset_values inst0: got %h want %h", got, RST_VALS);
      end
      got = {if1.spi_miso_o, if1.spi_miso_oe_o, if1.rx_data_o, if1.rx_valid_o,
             if1.tx_accept_o, if1.tx_underrun_o, if1.cs_active_o, if1.frame_end_o};
      vectors++;
      if (got !== RST_VALS) begin
         miscompares++;
         $display("FAIL reset_values inst1: got %h want %h", got, RST_VALS);
      end
      rst_n = 1'b1;
      wait_clks(4);
   endtask

   task automatic test_mode0_single();
      plan[0] = 8'hA5; mosi_b[0] = 8'h3C;
      run_frame(0, 1, "mode0_single");
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++) begin
         plan[k]   = 8'h10 + k;
         mosi_b[k] = 8'h01 + k[7:0];
      end
      run_frame(0, 4, "burst");
   endtask

   task automatic test_underrun();
      plan[0] = -1; plan[1] = -1;
      mosi_b[0] = 8'($urandom); mosi_b[1] = 8'($urandom);
      run_frame(0, 2, "underrun");
   endtask

   task automatic test_partial_frame();
      logic [7:0] rd;
      int r0, f0, u0, eu0;
      r0 = rxv_cnt[0]; f0 = fend_cnt[0]; u0 = urun_cnt[0]; eu0 = exp_urun[0];
      maybe_write(0, int'($urandom_range(0, 255)));
      set_cs(0, 1'b0);
      wait_clks(HALF);
      void'(model_load(0));
      spi_bits(0, 8'($urandom), 5, 1'b0, rd);
      cs_rise(0);
      vectors++;
      if (rxv_cnt[0] != r0 || fend_cnt[0] - f0 != 1 || if0.spi_miso_oe_o !== 1'b0) begin
         miscompares++;
         $display("FAIL partial rxv/frame_end/oe: got %0d,%0d,%b want 0,1,0",
                  rxv_cnt[0] - r0, fend_cnt[0] - f0, if0.spi_miso_oe_o);
      end
      vectors++;
      if (urun_cnt[0] - u0 != exp_urun[0] - eu0) begin
         miscompares++;
         $display("FAIL partial underrun_count: got %0d want %0d", urun_cnt[0] - u0, exp_urun[0] - eu0);
      end
      plan[0] = int'($urandom_range(0, 255)); mosi_b[0] = 8'h81;
      run_frame(0, 1, "after_partial");
   endtask

   task automatic test_mode3();
      plan[0] = 8'h5A; mosi_b[0] = 8'hC3;
      run_frame(1, 1, "mode3_single");
   endtask

   task automatic test_reset_abort();
      logic [7:0] rd;
      logic [14:0] got;
      int r0, u0, f0;
      maybe_write(0, 8'h66);
      set_cs(0, 1'b0);
      wait_clks(HALF);
      void'(model_load(0));
      spi_bits(0, 8'h99, 4, 1'b0, rd);
      rst_n = 1'b0;
      if0.spi_cs_i = 1'b1;
      if0.spi_clk_i = 1'b0;
      r0 = rxv_cnt[0]; u0 = urun_cnt[0]; f0 = fend_cnt[0];
      wait_clks(1);
      got = {if0.spi_miso_o, if0.spi_miso_oe_o, if0.rx_data_o, if0.rx_valid_o,
             if0.tx_accept_o, if0.tx_underrun_o, if0.cs_active_o, if0.frame_end_o};
      vectors++;
      if (got !== RST_VALS) begin
         miscompares++;
         $display("FAIL abort_reset_values: got %h want %h", got, RST_VALS);
      end
      rst_n = 1'b1;
      hold_v = '{1'b0, 1'b0};
      wait_clks(30);
      vectors++;
      if (rxv_cnt[0] != r0 || urun_cnt[0] != u0 || fend_cnt[0] != f0) begin
         miscompares++;
         $display("FAIL abort_pulses rxv/urun/fend: got %0d,%0d,%0d want 0,0,0",
                  rxv_cnt[0] - r0, urun_cnt[0] - u0, fend_cnt[0] - f0);
      end
      plan[0] = int'($urandom_range(0, 255)); mosi_b[0] = 8'h7E;
      run_frame(0, 1, "after_abort");
   endtask

   task automatic test_random();
      int inst, n;
      for (int it = 0; it < 8; it++) begin
         inst = int'($urandom_range(0, 1));
         n    = int'($urandom_range(1, 4));
         for (int k = 0; k < 8; k++) mosi_b[k] = 8'($urandom);
         for (int k = 0; k < 9; k++)
            plan[k] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 255));
         run_frame(inst, n, "random");
      end
   endtask

   initial begin
      test_reset();
      test_mode0_single();
      test_back_to_back();
      test_underrun();
      test_partial_frame();
      test_mode3();
      test_reset_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
